// File: rtl/dcache_ctrl.sv
// dcache_ctrl: 2-way set-associative, write-back, write-allocate data cache controller with register storage.
// Optional hit/miss statistics counters are enabled by defining DCACHE_STAT_EN.
`default_nettype none

module dcache_ctrl #(
  parameter int INDEX_W    = 5,
  parameter int WORD_OFF_W = 2,
  parameter int DATA_W     = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [31:0]         cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic [31:0]         mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic                lru_hit1,
  output logic                lru_hit2,
  output logic [INDEX_W-1:0]  lru_index,
  output logic                lru_update,
  output logic                lru_change,
`ifdef DCACHE_STAT_EN
  output logic [31:0]         stat_hit,
  output logic [31:0]         stat_miss,
`endif
  input  logic                lru_way_sel
);

  localparam int TAG_W = 32 - INDEX_W - WORD_OFF_W - 2;
  localparam int SETS  = 1 << INDEX_W;
  localparam int WORDS = 1 << WORD_OFF_W;

  typedef enum logic [1:0] {IDLE, LOOKUP, WB, REFILL} state_t;

  state_t state, next_state;

  logic [TAG_W-1:0]  tag_mem  [2][SETS];
  logic [DATA_W-1:0] data_mem [2][SETS][WORDS];
  logic [SETS-1:0]   valid    [2];
  logic [SETS-1:0]   dirty    [2];

  logic [31:0]           addr_q;
  logic                  we_q;
  logic [DATA_W-1:0]     wdata_q;
  logic                  victim;
  logic [WORD_OFF_W-1:0] beat;
  logic                  refilled;

  logic [TAG_W-1:0]      tag;
  logic [INDEX_W-1:0]    idx;
  logic [WORD_OFF_W-1:0] off;
  logic                  hit0, hit1, hit, hit_way, last_beat;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^{cpu_addr[1:0], addr_q[1:0]};

  assign tag       = addr_q[31 -: TAG_W];
  assign idx       = addr_q[WORD_OFF_W+2 +: INDEX_W];
  assign off       = addr_q[2 +: WORD_OFF_W];
  // Way 0 wins if both ways claim the same tag.
  assign hit0      = valid[0][idx] && (tag_mem[0][idx] == tag);
  assign hit1      = !hit0 && valid[1][idx] && (tag_mem[1][idx] == tag);
  assign hit       = hit0 || hit1;
  assign hit_way   = hit1;
  assign last_beat = &beat;

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    cpu_ready  = 1'b0;
    cpu_rdata  = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    lru_hit1   = 1'b0;
    lru_hit2   = 1'b0;
    lru_update = 1'b0;
    lru_change = 1'b0;
    case (state)
      IDLE: if (cpu_req) next_state = LOOKUP;
      LOOKUP: begin
        if (hit) begin
          cpu_ready  = 1'b1;
          lru_update = 1'b1;
          lru_hit1   = hit0;
          lru_hit2   = hit1;
          if (!we_q) cpu_rdata = data_mem[hit_way][idx][off];
          next_state = IDLE;
        end else if (valid[lru_way_sel][idx] && dirty[lru_way_sel][idx]) begin
          next_state = WB;
        end else begin
          next_state = REFILL;
        end
      end
      WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_mem[victim][idx], idx, beat, 2'b00};
        mem_wdata = data_mem[victim][idx][beat];
        if (mem_ack && last_beat) next_state = REFILL;
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {tag, idx, beat, 2'b00};
        if (mem_ack && last_beat) begin
          lru_change = 1'b1;
          next_state = LOOKUP;
        end
      end
      default: next_state = IDLE;
    endcase
    // Reset abandons any transaction in the same cycle it is asserted.
    if (!rstn) begin
      next_state = IDLE;
      cpu_ready  = 1'b0;
      cpu_rdata  = '0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      lru_hit1   = 1'b0;
      lru_hit2   = 1'b0;
      lru_update = 1'b0;
      lru_change = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      victim    <= 1'b0;
      beat      <= '0;
      refilled  <= 1'b0;
      lru_index <= '0;
      valid[0]  <= '0;
      valid[1]  <= '0;
      dirty[0]  <= '0;
      dirty[1]  <= '0;
    end else begin
      case (state)
        IDLE: if (cpu_req) begin
          addr_q    <= cpu_addr;
          we_q      <= cpu_we;
          wdata_q   <= cpu_wdata;
          lru_index <= cpu_addr[WORD_OFF_W+2 +: INDEX_W];
          refilled  <= 1'b0;
        end
        LOOKUP: begin
          if (hit) begin
            if (we_q) dirty[hit_way][idx] <= 1'b1;
            refilled <= 1'b0;
          end else begin
            victim <= lru_way_sel;
            beat   <= '0;
          end
        end
        WB: if (mem_ack) beat <= beat + 1'b1;
        REFILL: if (mem_ack) begin
          beat <= beat + 1'b1;
          if (last_beat) begin
            valid[victim][idx] <= 1'b1;
            dirty[victim][idx] <= 1'b0;
            refilled           <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag and data contents need no reset; only valid/dirty qualify them.
  always_ff @(posedge clk) begin
    if (state == LOOKUP && hit && we_q)
      data_mem[hit_way][idx][off] <= wdata_q;
    if (state == REFILL && mem_ack && rstn) begin
      data_mem[victim][idx][beat] <= mem_rdata;
      if (last_beat) tag_mem[victim][idx] <= tag;
    end
  end

`ifdef DCACHE_STAT_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      stat_hit  <= '0;
      stat_miss <= '0;
    end else if (state == LOOKUP) begin
      if (hit && !refilled && stat_hit != 32'hFFFF_FFFF) stat_hit <= stat_hit + 32'd1;
      if (!hit && stat_miss != 32'hFFFF_FFFF) stat_miss <= stat_miss + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: memory model with beat scoreboard, load-data scoreboard.
`default_nettype none

module tb_dcache_ctrl;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        lru_hit1, lru_hit2, lru_update, lru_change;
  logic [4:0]  lru_index;
  logic        lru_way_sel = 1'b0;
`ifdef DCACHE_STAT_EN
  logic [31:0] stat_hit, stat_miss;
`endif

  dcache_ctrl dut (
    .clk(clk), .rstn(rstn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .lru_hit1(lru_hit1), .lru_hit2(lru_hit2), .lru_index(lru_index),
    .lru_update(lru_update), .lru_change(lru_change),
`ifdef DCACHE_STAT_EN
    .stat_hit(stat_hit), .stat_miss(stat_miss),
`endif
    .lru_way_sel(lru_way_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  int total = 0;
  int bad = 0;
  logic [31:0] mem [logic [31:0]];
  beat_t beat_q[$];
  logic [31:0] rd_q[$];
  bit hold = 1'b0;
  int beats_seen = 0;
  int change_cnt = 0;
  int overlap_cnt = 0;
  int stray_hit_cnt = 0;

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory model: acks every requested beat on the spot unless held.
  always @(negedge clk) begin
    beat_t e;
    mem_ack = 1'b0;
    if (mem_req && !hold) begin
      mem_ack = 1'b1;
      mem_rdata = memval(mem_addr);
      beats_seen++;
      total++;
      if (beat_q.size() == 0) begin
        bad++;
        $display("FAIL mem_beat unexpected: got we=%0b addr=%h, required no beat", mem_we, mem_addr);
      end else begin
        e = beat_q.pop_front();
        if (mem_we !== e.we || mem_addr !== e.addr || (e.we && mem_wdata !== e.data)) begin
          bad++;
          $display("FAIL mem_beat: got we=%0b addr=%h wdata=%h, required we=%0b addr=%h wdata=%h",
                   mem_we, mem_addr, mem_wdata, e.we, e.addr, e.data);
        end
      end
      if (mem_we) mem[mem_addr] = mem_wdata;
    end
  end

  always @(negedge clk) begin
    #1;
    if (lru_change) change_cnt++;
    if (lru_change && lru_update) overlap_cnt++;
    if ((lru_hit1 || lru_hit2) && !lru_update) stray_hit_cnt++;
  end

  task automatic push_line(input bit we, input logic [31:0] base,
                           input logic [31:0] d0, d1, d2, d3);
    logic [31:0] d [4];
    beat_t b;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    for (int i = 0; i < 4; i++) begin
      b.we = we; b.addr = base + 32'(i * 4); b.data = d[i];
      beat_q.push_back(b);
    end
  endtask

  task automatic access(input logic [31:0] a, input bit we, input logic [31:0] wd,
                        input bit sel, input logic [31:0] exp_rd, input int exp_lat,
                        input int exp_way, input string name);
    int lat;
    logic [31:0] e;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; lru_way_sel = sel;
    if (!we) rd_q.push_back(exp_rd);
    @(negedge clk);
    cpu_req = 1'b0;
    lat = 1;
    while (!cpu_ready && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (cpu_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s timeout: cpu_ready=%b after %0d cycles, required 1", name, cpu_ready, lat);
      if (!we) void'(rd_q.pop_front());
    end else begin
      if (!we) begin
        e = rd_q.pop_front();
        total++;
        if (cpu_rdata !== e) begin
          bad++;
          $display("FAIL %s rdata: got %h, required %h", name, cpu_rdata, e);
        end
      end
      total++;
      if (lat != exp_lat) begin
        bad++;
        $display("FAIL %s latency: got %0d, required %0d", name, lat, exp_lat);
      end
      total++;
      if (lru_index !== a[8:4] || lru_update !== 1'b1 ||
          lru_hit1 !== (exp_way == 0) || lru_hit2 !== (exp_way == 1)) begin
        bad++;
        $display("FAIL %s lru: got idx=%0d upd=%b h1=%b h2=%b, required idx=%0d upd=1 way=%0d",
                 name, lru_index, lru_update, lru_hit1, lru_hit2, a[8:4], exp_way);
      end
    end
    total++;
    if (beat_q.size() != 0) begin
      bad++;
      $display("FAIL %s beats_left: got %0d, required 0", name, beat_q.size());
      beat_q.delete();
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (cpu_ready !== 0 || mem_req !== 0 || mem_we !== 0 || mem_addr !== 0 ||
        lru_index !== 0 || lru_update !== 0 || lru_change !== 0 || cpu_rdata !== 0) begin
      bad++;
      $display("FAIL reset_outputs: got rdy=%b req=%b addr=%h idx=%0d upd=%b chg=%b, required all 0",
               cpu_ready, mem_req, mem_addr, lru_index, lru_update, lru_change);
    end
    rstn = 1'b1;
  endtask

  task automatic test_cold_load;
    int c0;
    mem[32'h10] = 32'hA0; mem[32'h14] = 32'hA1; mem[32'h18] = 32'hA2; mem[32'h1C] = 32'hA3;
    push_line(1'b0, 32'h10, '0, '0, '0, '0);
    c0 = change_cnt;
    access(32'h10, 1'b0, '0, 1'b0, 32'hA0, 6, 0, "cold_load");
    total++;
    if (change_cnt - c0 != 1) begin
      bad++;
      $display("FAIL cold_load lru_change pulses: got %0d, required 1", change_cnt - c0);
    end
  endtask

  task automatic test_hit_load;
    int b0;
    b0 = beats_seen;
    access(32'h14, 1'b0, '0, 1'b0, 32'hA1, 1, 0, "hit_load");
    total++;
    if (beats_seen != b0) begin
      bad++;
      $display("FAIL hit_load mem_beats: got %0d, required 0", beats_seen - b0);
    end
`ifdef DCACHE_STAT_EN
    total++;
    if (stat_miss !== 32'd1 || stat_hit !== 32'd1) begin
      bad++;
      $display("FAIL stats: got hit=%0d miss=%0d, required hit=1 miss=1", stat_hit, stat_miss);
    end
`endif
  endtask

  task automatic test_evict_dirty;
    access(32'h18, 1'b1, 32'hDEADBEEF, 1'b0, '0, 1, 0, "store_hit");
    push_line(1'b0, 32'h210, '0, '0, '0, '0);
    access(32'h210, 1'b0, '0, 1'b1, memval(32'h210), 6, 1, "fill_way1");
    push_line(1'b1, 32'h10, 32'hA0, 32'hA1, 32'hDEADBEEF, 32'hA3);
    push_line(1'b0, 32'h410, '0, '0, '0, '0);
    access(32'h410, 1'b0, '0, 1'b0, memval(32'h410), 10, 0, "dirty_evict");
  endtask

  task automatic test_clean_replace;
    int b0;
    push_line(1'b0, 32'h610, '0, '0, '0, '0);
    access(32'h614, 1'b0, '0, 1'b1, memval(32'h614), 6, 1, "clean_replace");
    b0 = beats_seen;
    access(32'h418, 1'b0, '0, 1'b1, memval(32'h418), 1, 0, "way0_reread");
    access(32'h618, 1'b0, '0, 1'b0, memval(32'h618), 1, 1, "way1_reread");
    total++;
    if (beats_seen != b0) begin
      bad++;
      $display("FAIL reread mem_beats: got %0d, required 0", beats_seen - b0);
    end
    push_line(1'b0, 32'h10, '0, '0, '0, '0);
    access(32'h18, 1'b0, '0, 1'b1, 32'hDEADBEEF, 6, 1, "writeback_reload");
  endtask

  task automatic test_stall_reset;
    int b0, n;
    bit stable;
    logic [31:0] addr_s;
    beat_t b;
    b.we = 1'b0; b.data = '0;
    b.addr = 32'h810; beat_q.push_back(b);
    b.addr = 32'h814; beat_q.push_back(b);
    b0 = beats_seen;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h810; lru_way_sel = 1'b0;
    n = 0;
    do begin
      @(negedge clk); #2;
      cpu_req = 1'b0;
      n++;
    end while (beats_seen < b0 + 2 && n < 30);
    hold = 1'b1;
    @(negedge clk); #2;
    addr_s = mem_addr;
    stable = (mem_req === 1'b1) && (addr_s === 32'h818);
    repeat (10) begin
      @(negedge clk); #2;
      if (mem_req !== 1'b1 || mem_addr !== addr_s || mem_we !== 1'b0 || cpu_ready !== 1'b0)
        stable = 1'b0;
    end
    total++;
    if (!stable) begin
      bad++;
      $display("FAIL stall_stable: got req=%b addr=%h we=%b, required req=1 addr=00000818 we=0",
               mem_req, mem_addr, mem_we);
    end
    rstn = 1'b0;
    @(negedge clk); #2;
    total++;
    if (mem_req !== 1'b0 || lru_index !== 5'd0) begin
      bad++;
      $display("FAIL stall_reset: got req=%b idx=%0d, required req=0 idx=0", mem_req, lru_index);
    end
    rstn = 1'b1;
    hold = 1'b0;
    push_line(1'b0, 32'h810, '0, '0, '0, '0);
    access(32'h810, 1'b0, '0, 1'b0, memval(32'h810), 6, 0, "post_reset_miss");
  endtask

  task automatic test_ordering;
    total++;
    if (overlap_cnt != 0 || stray_hit_cnt != 0) begin
      bad++;
      $display("FAIL lru_ordering: got overlap=%0d stray_hit=%0d, required 0 and 0",
               overlap_cnt, stray_hit_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_cold_load();
    test_hit_load();
    test_evict_dirty();
    test_clean_replace();
    test_stall_reset();
    test_ordering();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end
endmodule

`default_nettype wire
